mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the ARM-subset core (ADD/SUB/AND/ORR, LDR/STR, B). It sequences a shared datapath in which one ALU and one memory port serve fetch, address generation and execute. It holds the instruction-step state machine, the NZCV flag register and the condition check. It drives every datapath mux select and write enable from the instruction fields, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- mem_ready  in  1  memory completes the current access this cycle
- Cond  in  4  instruction [31:28]
- Op  in  2  instruction [27:26]
- Funct  in  6  instruction [25:20]
- Rd  in  4  instruction [15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, this cycle
- mem_req  out  1  memory access active (FETCH, MEMREAD, MEMWRITE)
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc, RegSrc  out  2 each  immediate format and register-address selects
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States and default outputs: all enables 0, selects 0.
  - FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10, mem_req 1. When mem_ready=1: IRWrite 1, PCWrite 1, go to DECODE. Otherwise stay, with no writes.
  - DECODE: ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10 (R15 = PC+8). Capture cond_ex_q. Next state:
    - Op 01 → MEMADR.
    - Op 00 with Funct[5]=1 → EXECUTEI; with Funct[5]=0 → EXECUTER.
    - Op 10 → BRANCH.
    - Op 11 → FETCH, treated as a NOP.
  - MEMADR: ALUSrcA 0, ALUSrcB 01, ADD. Funct[0]=1 → MEMREAD, else → MEMWRITE.
  - MEMREAD: AdrSrc 1, mem_req 1. Go to MEMWB on mem_ready.
  - MEMWB: ResultSrc 01, RegW. Then FETCH.
  - MEMWRITE: AdrSrc 1, mem_req 1, MemW held until mem_ready. Then FETCH.
  - EXECUTER: ALUSrcB 00, ALUOp. EXECUTEI: ALUSrcB 01, ALUOp. Both go to ALUWB.
  - ALUWB: ResultSrc 00, RegW. Then FETCH.
  - BRANCH: ALUSrcA 0, ALUSrcB 01, ADD, ResultSrc 10, Branch. Then FETCH.
- ALU decode, active only in EXECUTE states. Funct[4:1] selects the operation: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other value gives ADD with no flag write.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ADD | SUB).
- Static selects, decoded from Op in every state:
  - Op 00: ImmSrc 00, RegSrc 00.
  - Op 01: ImmSrc 01; RegSrc 10 for STR, 00 for LDR.
  - Op 10: ImmSrc 10, RegSrc x1.
- Flag register flags_q[3:0] = {N,Z,C,V}:
  - [3:2] are loaded from ALUFlags when FlagW[1] & cond_ex_q.
  - [1:0] are loaded when FlagW[0] & cond_ex_q.
  - Loads happen on the EXECUTE clock edge.
- Condition codes, evaluated on flags_q:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z.
  - GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1.
  - 1111 evaluates to 0 (never).
- cond_ex_q is registered in DECODE. It gates the instruction's architectural writes:
  - RegWrite = RegW & cond_ex_q.
  - MemWrite = MemW & cond_ex_q.
  - PCWrite = NextPC | (PCS & cond_ex_q), where PCS = Branch | (RegW & Rd==1111).
- The FSM path is unchanged by the condition. A failed instruction still walks its states with writes suppressed. A failed STR still handshakes with mem_req but MemWrite stays 0.

## Timing
- Reset (reset_n=0 at a clk edge) sets state FETCH, flags_q 0000, cond_ex_q 0. While reset_n=0, mem_req, IRWrite, PCWrite, RegWrite and MemWrite are forced 0 combinationally.
- Reset mid-instruction discards it. Fetch restarts on the first cycle with reset_n=1.
- Cycles per instruction with mem_ready tied 1: B 3, DP 4, STR 4, LDR 5. Each wait cycle in FETCH, MEMREAD or MEMWRITE adds 1.
- mem_req stays high and address selects stay stable through all wait cycles. mem_ready outside the memory states is ignored.
- Flags written in EXECUTE are visible to the condition check of the next instruction's DECODE.

## Structure
- Package arm_mc_pkg holds:
  - the state enum;
  - ALUControl, ALUSrcB and ResultSrc encodings;
  - the condition-code constants.
- Sub-module cond_logic: combinational condition evaluation of Cond against flags_q. The FSM, decoders and flag register live in mc_controller.

## Test plan
- ADD R1,R2,R3 (Op 00, Funct 001000, Cond 1110), mem_ready 1 → states FETCH, DECODE, EXECUTER, ALUWB; RegWrite only in cycle 4; ALUControl 00.
- SUBS, ALUFlags 0100 in EXECUTE, then BEQ (Cond 0000) → flags_q = 0100 after the SUBS; branch PCWrite asserted in BRANCH.
- BNE with Z=1 → 3 cycles; PCWrite only in FETCH.
- LDR with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → 10 total cycles; IRWrite exactly once; RegWrite once, in MEMWB with ResultSrc 01.
- STR with Cond 1111 → MemWrite never 1; mem_req high in MEMWRITE; returns to FETCH.
- reset_n low during MEMWRITE → no MemWrite that cycle; FETCH next; flags_q 0000.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit:
// instruction-step states, datapath select encodings and condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Condition field values
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_logic.sv
// Combinational condition check of an instruction's Cond field against the
// stored NZCV flags.
//   cond    in  4  instruction condition field
//   flags   in  4  {N,Z,C,V} flag register
//   cond_ex out 1  instruction is to execute
module cond_logic
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // condition-code evaluation
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111: never
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: instruction-step FSM, ALU/select decoders, NZCV
// flag register and conditional gating of architectural writes.
//   clk, reset_n          clock, synchronous active-low reset
//   mem_ready             memory finishes the current access this cycle
//   Cond/Op/Funct/Rd      instruction fields
//   ALUFlags              {N,Z,C,V} produced by the ALU this cycle
//   mem_req               memory access active
//   IRWrite..MemWrite     write enables
//   AdrSrc..RegSrc        datapath mux selects and ALU operation
module mc_controller
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_ready,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t     state, next_state;
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       cond_ex;
  logic       mem_act, ir_w, next_pc, branch, reg_w, mem_w, alu_op;
  logic [1:0] flag_w;

  cond_logic u_cond (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // state, condition latch and flag register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) cond_ex_q <= cond_ex;
      // flag_w is only nonzero in the execute states
      if (flag_w[1] & cond_ex_q) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex_q) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // next state and per-state datapath controls
  always_comb begin
    next_state = state;
    mem_act    = 1'b0;
    ir_w       = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        mem_act   = 1'b1;
        if (mem_ready) begin
          ir_w       = 1'b1;
          next_pc    = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC+4 again: R15 reads as PC+8
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          2'b01:   next_state = S_MEMADR;
          2'b00:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        mem_act    = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_act    = 1'b1;
        mem_w      = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcB    = SRCB_RD2;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // ALU operation and flag-write decode, only in the execute states
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = ALU_ADD; flag_w = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = ALU_SUB; flag_w = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = ALU_AND; flag_w = {Funct[0], 1'b0}; end
        4'b1100: begin ALUControl = ALU_ORR; flag_w = {Funct[0], 1'b0}; end
        default: begin ALUControl = ALU_ADD; flag_w = 2'b00; end
      endcase
    end else begin
      ALUControl = ALU_ADD;
      flag_w     = 2'b00;
    end
  end

  // immediate format and register-address selects from Op
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b00:   begin ImmSrc = 2'b00; RegSrc = 2'b00; end
      2'b01:   begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
      2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
    endcase
  end

  // conditional gating of writes; reset forces all enables low at once
  always_comb begin
    if (!reset_n) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end else begin
      mem_req  = mem_act;
      IRWrite  = ir_w;
      PCWrite  = next_pc | ((branch | (reg_w & (Rd == 4'b1111))) & cond_ex_q);
      RegWrite = reg_w & cond_ex_q;
      MemWrite = mem_w & cond_ex_q;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_mc_controller;
  import arm_mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_ready;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_req, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_ready  (mem_ready),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .mem_req    (mem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mem_ready = 1'b1;
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; ALUFlags = 4'b1111;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, S_FETCH); end
    checks++; if (dut.flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", dut.flags_q); end
    checks++; if (dut.cond_ex_q !== 1'b0) begin errors++; $display("FAIL reset_condex got %b want 0", dut.cond_ex_q); end
    checks++; if ({mem_req, IRWrite, PCWrite, RegWrite, MemWrite} !== 5'b00000) begin errors++; $display("FAIL reset_enables got %b want 00000", {mem_req, IRWrite, PCWrite, RegWrite, MemWrite}); end
    next_cycle();
    ALUFlags = 4'b0000;
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    state_t exp_st [4] = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dut.state !== exp_st[i]) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, dut.state, exp_st[i]); end
      checks++; if (RegWrite !== (i == 3)) begin errors++; $display("FAIL add_regwrite[%0d] got %b want %b", i, RegWrite, (i == 3)); end
      if (i == 0) begin
        checks++; if ({mem_req, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc} !== 8'b1111_1010) begin errors++; $display("FAIL add_fetch_ctl got %b want 11111010", {mem_req, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc}); end
      end
      if (i == 2) begin
        checks++; if ({ALUControl, ALUSrcB} !== 4'b0000) begin errors++; $display("FAIL add_exec_ctl got %b want 0000", {ALUControl, ALUSrcB}); end
      end
      next_cycle();
    end
  endtask

  task automatic test_subs_beq;
    logic exp_pcw [3] = '{1'b1, 1'b0, 1'b1};
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b000101; Rd = 4'd1; ALUFlags = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++; if (ALUControl !== ALU_SUB) begin errors++; $display("FAIL subs_aluctl got %b want 01", ALUControl); end
      end
      next_cycle();
    end
    ALUFlags = 4'b0000;
    Cond = 4'b0000; Op = 2'b10; Funct = 6'b100000; Rd = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (dut.flags_q !== 4'b0100) begin errors++; $display("FAIL subs_flags got %b want 0100", dut.flags_q); end
      end
      checks++; if (PCWrite !== exp_pcw[i]) begin errors++; $display("FAIL beq_pcwrite[%0d] got %b want %b", i, PCWrite, exp_pcw[i]); end
      if (i == 2) begin
        checks++; if ({dut.state, ALUSrcA, ALUSrcB, RegSrc} !== {S_BRANCH, 1'b0, 2'b01, 2'b01}) begin errors++; $display("FAIL beq_branch_ctl got %b want %b", {dut.state, ALUSrcA, ALUSrcB, RegSrc}, {S_BRANCH, 1'b0, 2'b01, 2'b01}); end
      end
      next_cycle();
    end
  endtask

  task automatic test_bne_not_taken;
    logic exp_pcw [3] = '{1'b1, 1'b0, 1'b0};
    Cond = 4'b0001; Op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (PCWrite !== exp_pcw[i]) begin errors++; $display("FAIL bne_pcwrite[%0d] got %b want %b", i, PCWrite, exp_pcw[i]); end
      next_cycle();
    end
  endtask

  task automatic test_ldr_stall;
    logic   rdy [10]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    state_t exp_st [10] = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
                            S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    int irw_cnt = 0;
    logic exp_req;
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      exp_req = (i <= 2) || (i >= 5 && i <= 8);
      checks++; if (dut.state !== exp_st[i]) begin errors++; $display("FAIL ldr_state[%0d] got %0d want %0d", i, dut.state, exp_st[i]); end
      checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL ldr_memreq[%0d] got %b want %b", i, mem_req, exp_req); end
      checks++; if (RegWrite !== (i == 9)) begin errors++; $display("FAIL ldr_regwrite[%0d] got %b want %b", i, RegWrite, (i == 9)); end
      if (i >= 5 && i <= 8) begin
        checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL ldr_adrsrc[%0d] got %b want 1", i, AdrSrc); end
      end
      if (i == 9) begin
        checks++; if (ResultSrc !== RES_DATA) begin errors++; $display("FAIL ldr_resultsrc got %b want 01", ResultSrc); end
      end
      if (IRWrite === 1'b1) irw_cnt++;
      next_cycle();
    end
    mem_ready = 1'b1;
    checks++; if (irw_cnt !== 1) begin errors++; $display("FAIL ldr_irwrite_count got %0d want 1", irw_cnt); end
  endtask

  task automatic test_str_never;
    state_t exp_st [4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
    Cond = 4'b1111; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dut.state !== exp_st[i]) begin errors++; $display("FAIL str_state[%0d] got %0d want %0d", i, dut.state, exp_st[i]); end
      checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL str_memwrite[%0d] got %b want 0", i, MemWrite); end
      if (i == 3) begin
        checks++; if ({mem_req, AdrSrc, RegSrc, ImmSrc} !== 6'b11_10_01) begin errors++; $display("FAIL str_memwrite_ctl got %b want 111001", {mem_req, AdrSrc, RegSrc, ImmSrc}); end
      end
      next_cycle();
    end
  endtask

  task automatic test_orr_pc;
    state_t exp_st [4] = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b111000; Rd = 4'b1111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dut.state !== exp_st[i]) begin errors++; $display("FAIL orr_state[%0d] got %0d want %0d", i, dut.state, exp_st[i]); end
      if (i == 2) begin
        checks++; if ({ALUControl, ALUSrcB} !== 4'b1101) begin errors++; $display("FAIL orr_exec_ctl got %b want 1101", {ALUControl, ALUSrcB}); end
      end
      if (i == 3) begin
        checks++; if ({PCWrite, RegWrite} !== 2'b11) begin errors++; $display("FAIL orr_pc_write got %b want 11", {PCWrite, RegWrite}); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (dut.flags_q !== 4'b0100) begin errors++; $display("FAIL orr_flags got %b want 0100", dut.flags_q); end
    next_cycle();
    // the extra sampled cycle was a FETCH with mem_ready high: finish the ORR-again
    // instruction cleanly by letting it walk out before the next test
    for (int i = 0; i < 3; i++) next_cycle();
  endtask

  task automatic test_reset_mid;
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({dut.state, MemWrite, mem_req} !== {S_MEMWRITE, 1'b1, 1'b1}) begin errors++; $display("FAIL mid_str_memwrite got %b want %b", {dut.state, MemWrite, mem_req}, {S_MEMWRITE, 1'b1, 1'b1}); end
    next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({MemWrite, mem_req} !== 2'b00) begin errors++; $display("FAIL mid_reset_forced got %b want 00", {MemWrite, mem_req}); end
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL mid_reset_state got %0d want %0d", dut.state, S_FETCH); end
    checks++; if (dut.flags_q !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags got %b want 0000", dut.flags_q); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_reset_fetch got %b want 1", mem_req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subs_beq();
    test_bne_not_taken();
    test_ldr_stall();
    test_str_never();
    test_orr_pc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
